// File: rtl/mmu_dport_arb_pkg.sv
// mmu_dport_arb_pkg: shared state, owner and dcache-op encodings for the MMU dcache port arbiter
package mmu_dport_arb_pkg;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;
    typedef enum logic {ARB_OWN_PTW = 1'b0, ARB_OWN_LSU = 1'b1} arb_own_t;
    localparam int DOP_RD    = 0;
    localparam int DOP_WR    = 1;
    localparam int DOP_FLUSH = 2;
    localparam int DOP_INV   = 3;
    localparam int DOP_WB    = 4;
    localparam int DOP_N     = 5;
    typedef logic [DOP_N-1:0] dop_t;
    function automatic dop_t lsu_op_sel(input logic wr, input logic rd, input logic flush,
                                        input logic inv, input logic wb);
        return wr    ? dop_t'(1 << DOP_WR)    :
               rd    ? dop_t'(1 << DOP_RD)    :
               flush ? dop_t'(1 << DOP_FLUSH) :
               inv   ? dop_t'(1 << DOP_INV)   :
               wb    ? dop_t'(1 << DOP_WB)    : '0;
    endfunction
endpackage

// File: rtl/mmu_arb_wdog.sv
// mmu_arb_wdog: saturating busy-cycle counter that flags expiry at TIMEOUT (0 disables)
module mmu_arb_wdog #(
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [TMO_W-1:0] r_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) r_cnt <= '0;
        else if (en_i && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
    assign expired_o = (TIMEOUT != 0) && (r_cnt == TMO_W'(TIMEOUT));
endmodule

// File: rtl/mmu_dport_arb.sv
// mmu_dport_arb: shares the dcache port between the PTW and the LSU, one latched transaction at a time
module mmu_dport_arb
    import mmu_dport_arb_pkg::*;
#(
    parameter bit ARB_RR  = 1'b0,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ptw_rd_i,
    input  logic [31:0] ptw_addr_i,
    output logic [31:0] ptw_value_o,
    output logic        ptw_valid_o,
    output logic        ptw_error_o,
    input  logic        lsu_rd_i,
    input  logic        lsu_wr_i,
    input  logic        lsu_flush_i,
    input  logic        lsu_invalidate_i,
    input  logic        lsu_writeback_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    input  logic [3:0]  lsu_mask_i,
    output logic [31:0] lsu_value_o,
    output logic        lsu_valid_o,
    output logic        lsu_error_o,
    output logic [31:0] dcache_addr_o,
    output logic [31:0] dcache_value_o,
    output logic [3:0]  dcache_mask_o,
    output logic        dcache_rd_o,
    output logic        dcache_wr_o,
    output logic        dcache_flush_o,
    output logic        dcache_invalidate_o,
    output logic        dcache_writeback_o,
    input  logic [31:0] dcache_in_value_i,
    input  logic        dcache_in_valid_i,
    output logic        busy_o
);
    arb_state_t  r_state;
    arb_own_t    r_owner;
    arb_own_t    r_last;
    dop_t        r_op;
    logic [31:0] r_addr;
    logic [31:0] r_value;
    logic [3:0]  r_mask;
    logic        r_ptw_err;
    logic        r_lsu_err;
    dop_t        w_lsu_op;
    logic        w_busy;
    logic        w_req;
    logic        w_grant_ptw;
    logic        w_done;
    logic        w_expired;
    arb_own_t    w_own;
    assign w_lsu_op    = lsu_op_sel(lsu_wr_i, lsu_rd_i, lsu_flush_i, lsu_invalidate_i, lsu_writeback_i);
    assign w_busy      = r_state == ARB_BUSY;
    assign w_req       = ptw_rd_i || (w_lsu_op != '0);
    // On a tie the PTW wins unless round-robin says it was served last
    assign w_grant_ptw = ptw_rd_i && (w_lsu_op == '0 || !ARB_RR || r_last == ARB_OWN_LSU);
    assign w_own       = w_grant_ptw ? ARB_OWN_PTW : ARB_OWN_LSU;
    assign w_done      = w_busy && dcache_in_valid_i;
    mmu_arb_wdog #(.TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (!w_busy && w_req),
        .en_i      (w_busy),
        .expired_o (w_expired)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ARB_IDLE;
            r_owner   <= ARB_OWN_PTW;
            r_last    <= ARB_OWN_LSU;
            r_op      <= '0;
            r_addr    <= '0;
            r_value   <= '0;
            r_mask    <= '0;
            r_ptw_err <= 1'b0;
            r_lsu_err <= 1'b0;
        end else begin
            r_ptw_err <= 1'b0;
            r_lsu_err <= 1'b0;
            if (!w_busy) begin
                if (w_req) begin
                    r_state <= ARB_BUSY;
                    r_owner <= w_own;
                    r_last  <= w_own;
                    r_addr  <= w_grant_ptw ? ptw_addr_i : lsu_addr_i;
                    r_value <= w_grant_ptw ? '0 : lsu_data_i;
                    r_mask  <= (w_grant_ptw || !w_lsu_op[DOP_WR]) ? 4'hf : lsu_mask_i;
                    r_op    <= w_grant_ptw ? dop_t'(1 << DOP_RD) : w_lsu_op;
                end
            end else if (dcache_in_valid_i || w_expired) begin
                r_state   <= ARB_IDLE;
                r_op      <= '0;
                r_ptw_err <= !dcache_in_valid_i && r_owner == ARB_OWN_PTW;
                r_lsu_err <= !dcache_in_valid_i && r_owner == ARB_OWN_LSU;
            end
        end
    end
    assign ptw_valid_o         = w_done && r_owner == ARB_OWN_PTW;
    assign lsu_valid_o         = w_done && r_owner == ARB_OWN_LSU;
    assign ptw_value_o         = ptw_valid_o ? dcache_in_value_i : '0;
    assign lsu_value_o         = lsu_valid_o ? dcache_in_value_i : '0;
    assign ptw_error_o         = r_ptw_err;
    assign lsu_error_o         = r_lsu_err;
    assign dcache_addr_o       = r_addr;
    assign dcache_value_o      = r_value;
    assign dcache_mask_o       = r_mask;
    assign dcache_rd_o         = r_op[DOP_RD];
    assign dcache_wr_o         = r_op[DOP_WR];
    assign dcache_flush_o      = r_op[DOP_FLUSH];
    assign dcache_invalidate_o = r_op[DOP_INV];
    assign dcache_writeback_o  = r_op[DOP_WB];
    assign busy_o              = w_busy;
endmodule

// File: tb/tb_mmu_dport_arb.sv
// tb_mmu_dport_arb: directed checks of the dcache port arbiter (fixed-priority/TIMEOUT=4 and round-robin instances)
module tb_mmu_dport_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ptw_rd = 1'b0;
    logic [31:0] ptw_addr = '0;
    logic        lsu_rd = 1'b0, lsu_wr = 1'b0, lsu_fl = 1'b0, lsu_inv = 1'b0, lsu_wb = 1'b0;
    logic [31:0] lsu_addr = '0, lsu_data = '0;
    logic [3:0]  lsu_mask = '0;
    logic [31:0] dc_val = '0;
    logic        dc_vld = 1'b0;
    logic [31:0] a_ptw_value, a_lsu_value, a_addr, a_value;
    logic        a_ptw_valid, a_ptw_error, a_lsu_valid, a_lsu_error, a_busy;
    logic [3:0]  a_mask;
    logic        a_rd, a_wr, a_fl, a_inv, a_wb;
    logic [31:0] b_ptw_value, b_lsu_value, b_addr, b_value;
    logic        b_ptw_valid, b_ptw_error, b_lsu_valid, b_lsu_error, b_busy;
    logic [3:0]  b_mask;
    logic        b_rd, b_wr, b_fl, b_inv, b_wb;
    logic [4:0]  a_ops;
    int          n_chk = 0;
    int          n_fail = 0;
    assign a_ops = {a_wb, a_inv, a_fl, a_wr, a_rd};
    always #5 clk = ~clk;
    mmu_dport_arb #(.ARB_RR(1'b0), .TIMEOUT(4), .TMO_W(8)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .ptw_rd_i(ptw_rd), .ptw_addr_i(ptw_addr), .ptw_value_o(a_ptw_value),
        .ptw_valid_o(a_ptw_valid), .ptw_error_o(a_ptw_error),
        .lsu_rd_i(lsu_rd), .lsu_wr_i(lsu_wr), .lsu_flush_i(lsu_fl), .lsu_invalidate_i(lsu_inv),
        .lsu_writeback_i(lsu_wb), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data), .lsu_mask_i(lsu_mask),
        .lsu_value_o(a_lsu_value), .lsu_valid_o(a_lsu_valid), .lsu_error_o(a_lsu_error),
        .dcache_addr_o(a_addr), .dcache_value_o(a_value), .dcache_mask_o(a_mask),
        .dcache_rd_o(a_rd), .dcache_wr_o(a_wr), .dcache_flush_o(a_fl),
        .dcache_invalidate_o(a_inv), .dcache_writeback_o(a_wb),
        .dcache_in_value_i(dc_val), .dcache_in_valid_i(dc_vld), .busy_o(a_busy)
    );
    mmu_dport_arb #(.ARB_RR(1'b1), .TIMEOUT(0), .TMO_W(8)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .ptw_rd_i(ptw_rd), .ptw_addr_i(ptw_addr), .ptw_value_o(b_ptw_value),
        .ptw_valid_o(b_ptw_valid), .ptw_error_o(b_ptw_error),
        .lsu_rd_i(lsu_rd), .lsu_wr_i(lsu_wr), .lsu_flush_i(lsu_fl), .lsu_invalidate_i(lsu_inv),
        .lsu_writeback_i(lsu_wb), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data), .lsu_mask_i(lsu_mask),
        .lsu_value_o(b_lsu_value), .lsu_valid_o(b_lsu_valid), .lsu_error_o(b_lsu_error),
        .dcache_addr_o(b_addr), .dcache_value_o(b_value), .dcache_mask_o(b_mask),
        .dcache_rd_o(b_rd), .dcache_wr_o(b_wr), .dcache_flush_o(b_fl),
        .dcache_invalidate_o(b_inv), .dcache_writeback_o(b_wb),
        .dcache_in_value_i(dc_val), .dcache_in_valid_i(dc_vld), .busy_o(b_busy)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask
    initial begin
        int c;
        int pre_err;
        do_reset;
        #1;
        check("rst_busy", a_busy, 0);
        check("rst_ops", a_ops, 0);
        check("rst_addr", a_addr, 0);
        check("rst_mask", a_mask, 0);
        check("rst_valid_err", {a_ptw_valid, a_lsu_valid, a_ptw_error, a_lsu_error}, 0);
        // 1: lone PTW read
        ptw_rd = 1'b1;
        ptw_addr = 32'h8000_1000;
        tick;
        check("t1_busy", a_busy, 1);
        check("t1_ops", a_ops, 5'b00001);
        check("t1_addr", a_addr, 32'h8000_1000);
        check("t1_mask", a_mask, 4'hf);
        tick;
        tick;
        tick;
        dc_vld = 1'b1;
        dc_val = 32'h2000_00CF;
        #1;
        check("t1_ptw_valid", a_ptw_valid, 1);
        check("t1_ptw_value", a_ptw_value, 32'h2000_00CF);
        check("t1_lsu_valid", a_lsu_valid, 0);
        check("t1_lsu_value", a_lsu_value, 0);
        ptw_rd = 1'b0;
        tick;
        dc_vld = 1'b0;
        #1;
        check("t1_idle_busy", a_busy, 0);
        check("t1_idle_ops", a_ops, 0);
        check("t1_idle_value", a_ptw_value, 0);
        // 2: fixed priority ties go to the PTW
        lsu_rd = 1'b1;
        lsu_addr = 32'h9000_0000;
        for (int i = 0; i < 3; i++) begin
            ptw_rd = 1'b1;
            ptw_addr = 32'h8000_1000 + 32'(i * 16);
            tick;
            check("t2_tie_addr", a_addr, 32'h8000_1000 + 32'(i * 16));
            dc_vld = 1'b1;
            dc_val = 32'h1111_0000 + 32'(i);
            #1;
            check("t2_tie_ptw_valid", a_ptw_valid, 1);
            check("t2_tie_lsu_valid", a_lsu_valid, 0);
            tick;
            dc_vld = 1'b0;
            if (i == 2) ptw_rd = 1'b0;
            check("t2_gap_busy", a_busy, 0);
        end
        tick;
        check("t2_lsu_addr", a_addr, 32'h9000_0000);
        check("t2_lsu_ops", a_ops, 5'b00001);
        dc_vld = 1'b1;
        dc_val = 32'h5555_AAAA;
        #1;
        check("t2_lsu_valid", a_lsu_valid, 1);
        check("t2_lsu_value", a_lsu_value, 32'h5555_AAAA);
        check("t2_ptw_valid", a_ptw_valid, 0);
        lsu_rd = 1'b0;
        tick;
        dc_vld = 1'b0;
        // 4: LSU write latched while the requester changes its inputs
        lsu_wr = 1'b1;
        lsu_addr = 32'h8000_0040;
        lsu_data = 32'hDEAD_BEEF;
        lsu_mask = 4'b0011;
        tick;
        lsu_wr = 1'b0;
        lsu_rd = 1'b1;
        lsu_addr = 32'h0;
        lsu_data = 32'h0;
        lsu_mask = 4'hf;
        tick;
        tick;
        check("t4_addr", a_addr, 32'h8000_0040);
        check("t4_value", a_value, 32'hDEAD_BEEF);
        check("t4_mask", a_mask, 4'b0011);
        check("t4_ops", a_ops, 5'b00010);
        dc_vld = 1'b1;
        #1;
        check("t4_lsu_valid", a_lsu_valid, 1);
        lsu_rd = 1'b0;
        tick;
        dc_vld = 1'b0;
        check("t4_idle_ops", a_ops, 0);
        // LSU op priority: flush beats invalidate, mask forced to all ones
        lsu_fl = 1'b1;
        lsu_inv = 1'b1;
        lsu_mask = 4'b0101;
        tick;
        check("t4_prio_ops", a_ops, 5'b00100);
        check("t4_prio_mask", a_mask, 4'hf);
        dc_vld = 1'b1;
        lsu_fl = 1'b0;
        lsu_inv = 1'b0;
        tick;
        dc_vld = 1'b0;
        // 5: watchdog abort of a hung LSU read
        lsu_rd = 1'b1;
        lsu_addr = 32'h8000_3000;
        tick;
        c = 1;
        pre_err = 0;
        for (int k = 0; k < 20 && a_busy; k++) begin
            tick;
            if (a_busy) c++;
            if (a_busy && (a_lsu_error || a_ptw_error)) pre_err++;
        end
        check("t5_busy_cycles", c, 5);
        check("t5_early_err", pre_err, 0);
        check("t5_lsu_error", a_lsu_error, 1);
        check("t5_ptw_error", a_ptw_error, 0);
        lsu_rd = 1'b0;
        ptw_rd = 1'b1;
        ptw_addr = 32'h8000_2000;
        dc_vld = 1'b1;
        dc_val = 32'hBAD0_BAD0;
        #1;
        check("t5_stale_lsu_valid", a_lsu_valid, 0);
        check("t5_stale_ptw_valid", a_ptw_valid, 0);
        tick;
        dc_vld = 1'b0;
        check("t5_err_pulse_end", a_lsu_error, 0);
        check("t5_ptw_grant_addr", a_addr, 32'h8000_2000);
        check("t5_ptw_grant_ops", a_ops, 5'b00001);
        dc_vld = 1'b1;
        #1;
        check("t5_ptw_valid", a_ptw_valid, 1);
        ptw_rd = 1'b0;
        tick;
        dc_vld = 1'b0;
        // 6: reset while busy aborts silently
        ptw_rd = 1'b1;
        ptw_addr = 32'h8000_4000;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ptw_rd = 1'b0;
        check("t6_ops", a_ops, 0);
        check("t6_addr", a_addr, 0);
        check("t6_busy", a_busy, 0);
        check("t6_err", {a_ptw_error, a_lsu_error}, 0);
        tick;
        dc_vld = 1'b1;
        #1;
        check("t6_late_valid", {a_ptw_valid, a_lsu_valid}, 0);
        tick;
        dc_vld = 1'b0;
        check("t6_still_idle", a_busy, 0);
        check("t6_no_err", {a_ptw_error, a_lsu_error}, 0);
        // 3: round-robin alternation with both held
        do_reset;
        ptw_rd = 1'b1;
        ptw_addr = 32'h8000_1000;
        lsu_rd = 1'b1;
        lsu_addr = 32'h9000_0000;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t3_busy", b_busy, 1);
            check("t3_addr", b_addr, (i % 2 == 0) ? 32'h8000_1000 : 32'h9000_0000);
            dc_vld = 1'b1;
            #1;
            check("t3_ptw_valid", b_ptw_valid, (i % 2 == 0) ? 1 : 0);
            check("t3_lsu_valid", b_lsu_valid, (i % 2 == 0) ? 0 : 1);
            tick;
            dc_vld = 1'b0;
            check("t3_gap", b_busy, 0);
        end
        ptw_rd = 1'b0;
        lsu_rd = 1'b0;
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
